// File: rtl/sel_mux_pipe.sv
// Parametrised N-way word select feeding a 2-entry valid/ready elastic buffer.
// Optional saturating error counter port (err_cnt) enabled by macro SEL_MUX_ERRCNT_EN.
module sel_mux_pipe #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 13,
  parameter int               SEL_W       = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    err_clr,
`ifdef SEL_MUX_ERRCNT_EN
  output logic [7:0]              err_cnt,
`endif
  output logic                    sel_err
);

  if ((2 ** SEL_W) < NUM_IN) begin : g_bad_sel_w
    $error("sel_mux_pipe: SEL_W too narrow for NUM_IN");
  end
  if (NUM_IN < 2 || NUM_IN > 64) begin : g_bad_num_in
    $error("sel_mux_pipe: NUM_IN must be in 2..64");
  end

  logic [WIDTH:0]   r_mem [2];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;
  logic             r_sel_err;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_hit;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;
  logic             w_head_nxt;
  logic             w_tail_nxt;
  logic [WIDTH:0]   w_new_entry;
  logic [WIDTH:0]   w_head_entry_nxt;

  // Out-of-range codes never index the bus; they fall through to DEFAULT_VAL.
  always_comb begin
    w_sel_data = DEFAULT_VAL;
    w_sel_hit  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_data = in_bus[k*WIDTH +: WIDTH];
        w_sel_hit  = 1'b1;
      end
    end
  end

  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = r_out_valid & out_ready;
  assign w_head_nxt  = r_head ^ w_pop;
  assign w_tail_nxt  = r_tail ^ w_push;
  assign w_new_entry = {~w_sel_hit, w_sel_data};

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Look ahead to the head entry after this edge so the outputs stay registered.
  always_comb begin
    w_head_entry_nxt = r_mem[w_head_nxt];
    if (w_push && (r_tail == w_head_nxt)) begin
      w_head_entry_nxt = w_new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      r_count     <= 2'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_new_entry;
      end
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
      if (w_count_nxt != 2'd0) begin
        r_out_err  <= w_head_entry_nxt[WIDTH];
        r_out_data <= w_head_entry_nxt[WIDTH-1:0];
      end
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_push && !w_sel_hit) begin
      r_sel_err <= 1'b1;
    end else if (err_clr) begin
      r_sel_err <= 1'b0;
    end
  end

`ifdef SEL_MUX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // An increment together with a clear restarts the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_push && !w_sel_hit) begin
      if (err_clr) begin
        r_err_cnt <= 8'd1;
      end else if (r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end else if (err_clr) begin
      r_err_cnt <= 8'd0;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed bench for sel_mux_pipe: scoreboard of expected {err,data} words,
// pushed on accept and popped when the DUT hands a word to the consumer.
module tb_sel_mux_pipe;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 13;
  localparam int SEL_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_clr;
  logic                    sel_err;
`ifdef SEL_MUX_ERRCNT_EN
  logic [7:0]              err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit last_acc;
  logic [WIDTH:0] sb [$];

  sel_mux_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .DEFAULT_VAL('0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
`ifdef SEL_MUX_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] model(input logic [SEL_W-1:0] s);
    if (int'(s) < NUM_IN) return {1'b0, 32'h1000_0000 + 32'(s)};
    return {1'b1, 32'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: decide handshakes from pre-edge values, then advance to edge+1.
  task automatic cycle();
    logic [WIDTH:0] e;
    bit pp;
    last_acc = in_valid && in_ready;
    pp       = out_valid && out_ready;
    if (pp) begin
      e = (sb.size() > 0) ? sb.pop_front() : {(WIDTH+1){1'bx}};
      chk("pop_word", 64'({out_err, out_data}), 64'(e));
    end
    if (last_acc) sb.push_back(model(sel));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() > 0; i++) cycle();
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < NUM_IN; k++) in_bus[k*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(k);
    rst_n = 1'b0; sel = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_sel_err", 64'(sel_err), 64'd0);
    #2 rst_n = 1'b1;
    #1 chk("rel_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_high", 64'(in_ready), 64'd1);

    // stream 0,5,12 with 1-cycle latency
    out_ready = 1'b1; in_valid = 1'b1; sel = 4'd0;
    cycle();
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_data", 64'(out_data), 64'h1000_0000);
    sel = 4'd5;  cycle();
    chk("stream_data5", 64'(out_data), 64'h1000_0005);
    sel = 4'd12; cycle();
    chk("stream_data12", 64'(out_data), 64'h1000_000C);
    drain();

    // backpressure: third word held until space frees
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 4'd1; cycle();
    chk("bp_ready_after1", 64'(in_ready), 64'd1);
    sel = 4'd2; cycle();
    chk("bp_ready_after2", 64'(in_ready), 64'd0);
    sel = 4'd3; cycle();
    chk("bp_third_held", 64'(last_acc), 64'd0);
    chk("bp_ready_held", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    begin
      int n_acc = 0;
      for (int i = 0; i < 6 && n_acc == 0; i++) begin
        cycle();
        if (last_acc) n_acc++;
      end
      chk("bp_third_accepted", 64'(n_acc), 64'd1);
    end
    drain();

    // illegal selects
    out_ready = 1'b1; in_valid = 1'b1;
    sel = 4'd13; cycle();
    chk("ill13_data", 64'(out_data), 64'd0);
    chk("ill13_err", 64'(out_err), 64'd1);
    chk("ill13_sel_err", 64'(sel_err), 64'd1);
    sel = 4'd15; cycle();
    chk("ill15_err", 64'(out_err), 64'd1);
    sel = 4'd7; cycle();
    chk("legal_after_ill_err", 64'(out_err), 64'd0);
    chk("sel_err_sticky", 64'(sel_err), 64'd1);
    drain();
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("sel_err_cleared", 64'(sel_err), 64'd0);
    err_clr = 1'b1; in_valid = 1'b1; sel = 4'd14; cycle();
    err_clr = 1'b0;
    chk("set_wins_over_clr", 64'(sel_err), 64'd1);
    drain();
    err_clr = 1'b1; cycle(); err_clr = 1'b0;

    // simultaneous push/pop at count=1
    out_ready = 1'b1; in_valid = 1'b1; sel = 4'd4;
    cycle();
    for (int i = 0; i < 10; i++) begin
      sel = 4'($urandom_range(0, NUM_IN - 1));
      cycle();
      chk("pp_in_ready", 64'(in_ready), 64'd1);
      chk("pp_out_valid", 64'(out_valid), 64'd1);
    end
    drain();

    // async reset with 2 entries buffered
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 4'd9;  cycle();
    sel = 4'd13; cycle();
    in_valid = 1'b0;
    chk("pre_rst_sel_err", 64'(sel_err), 64'd1);
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_sel_err", 64'(sel_err), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("post_rst_no_stale", 64'(out_valid), 64'd0);

`ifdef SEL_MUX_ERRCNT_EN
    out_ready = 1'b1; in_valid = 1'b1; sel = 4'd15;
    for (int i = 0; i < 300; i++) cycle();
    chk("errcnt_saturate", 64'(err_cnt), 64'd255);
    drain();
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("errcnt_cleared", 64'(err_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
